serial_signed_comparator: RTL
=============================

# serial_signed_comparator

Bit-serial counterpart of the team's parallel signed comparator. It accepts two two's-complement operands streamed MSB-first, one bit-pair per accepted beat, and returns a registered less/equal/greater verdict through a valid/ready handshake. It sits at the receive end of serial operand links where the parallel `altb/aeqb/agtb` result is needed without a deserializer.

## Interface
- `WIDTH`, 4: operand width in bits; legal range 1..32.
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: a bit-pair is presented.
- `in_first` input 1: the presented pair is the MSB (sign bit) of a new word.
- `a_bit` input 1: current bit of operand a.
- `b_bit` input 1: current bit of operand b.
- `in_ready` output 1: block accepts the pair this cycle.
- `out_valid` output 1: the verdict is valid.
- `out_ready` input 1: the consumer takes the verdict.
- `altb` output 1: a < b (signed).
- `aeqb` output 1: a == b.
- `agtb` output 1: a > b (signed).
- `err` output 1: one-cycle framing-error pulse.

## Operation
- A beat is accepted when `in_valid & in_ready`.
- States: IDLE, SHIFT, HOLD.
- IDLE: `in_ready`=1.
  - Accepted beat with `in_first`=1 loads the sign bit and sets the bit count to 1, then goes to SHIFT. If `WIDTH`==1, it goes straight to HOLD.
  - Accepted beat with `in_first`=0 is dropped, `err` pulses, and the state stays IDLE.
- Sign-bit rule: if `a_bit`!=`b_bit`, the verdict is decided. `a_bit`=1 gives lt; `a_bit`=0 gives gt.
- SHIFT: `in_ready`=1.
  - Each accepted beat increments the count.
  - If the verdict is still undecided and `a_bit`!=`b_bit`, it is decided now: `a_bit`=1 gives gt, `a_bit`=0 gives lt.
  - Once decided, later bits are ignored.
  - On the WIDTH-th beat, go to HOLD. An undecided verdict at that point is eq.
- `in_first`=1 on an accepted beat in SHIFT aborts the current word. `err` pulses, and the beat is treated as the MSB of a new word (count=1, decision re-evaluated). The state stays SHIFT.
- HOLD: `in_ready`=0 and `out_valid`=1.
  - Exactly one of `altb/aeqb/agtb` is 1, and the flags stay stable until the handshake completes.
  - `out_ready`=1 returns the block to IDLE on the next cycle.
- Outside HOLD, `altb`, `aeqb`, `agtb` and `out_valid` are all 0.
- Bit count width is $clog2(WIDTH+1). It never wraps, because it is reset on every word start.

## Timing
- Reset, checked on the cycle after `reset` is sampled high:
  - state = IDLE.
  - `out_valid`, `altb`, `aeqb`, `agtb`, `err` = 0.
  - `in_ready` = 1.
- `reset` mid-word or in HOLD discards the word and its verdict. No `err` pulse is produced.
- `in_ready` is a function of state only. It has no combinational path from `in_valid` or `out_ready`.
- `out_valid` rises on the cycle after the WIDTH-th beat is accepted.
- `err` is registered and asserts on the cycle after the offending beat.
- Minimum period per word is WIDTH+1 cycles: WIDTH beats plus one HOLD cycle with `out_ready`=1.
- Gaps with `in_valid`=0 in SHIFT are legal. State and count hold during a gap.
- `in_valid` while in HOLD is not accepted. The upstream must hold the beat until `in_ready` returns.

## Structure
- Shared package `cmp_pkg` holds:
  - the state enum (IDLE, SHIFT, HOLD);
  - the verdict encoding constants (LT, EQ, GT);
  - the default `WIDTH`.
- One sub-module, `serial_cmp_cell`: combinational decision logic with inputs (a_bit, b_bit, is_msb, decided, verdict) and outputs (next decided, next verdict). The FSM, counter and handshake stay in the top module.

## Test plan
- a=0000, b=1001 (4 beats, then `out_ready`=1) -> `out_valid` on cycle 5, `agtb`=1, others 0.
- a=0011, b=0011 -> `aeqb`=1.
- a=1111, b=0000 -> `altb`=1.
- a=0111, b=1000 -> `agtb`=1.
- a=0101, b=1000 with `out_ready` held 0 for 3 cycles:
  - `agtb` and `out_valid` stay stable;
  - `in_ready`=0 throughout;
  - on release, IDLE is reached the next cycle.
- Framing and reset cases:
  - `in_first` on beat 3 of a word -> `err` pulse, word restarts, and the following 0010/1110 gives `agtb`=1.
  - A non-first beat in IDLE -> `err` pulse and the beat is dropped.
  - `reset` mid-word -> all outputs 0, `in_ready`=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the serial signed comparator: FSM states,
// verdict encoding and the default operand width.
package cmp_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Verdict encoding. EQ is the all-zero value so an undecided word
   // naturally reads as equal once all bits have been seen.
   localparam logic [1:0] EQ = 2'd0;
   localparam logic [1:0] LT = 2'd1;
   localparam logic [1:0] GT = 2'd2;

endpackage

// File: rtl/serial_cmp_cell.sv
// Combinational per-beat decision step of the MSB-first signed compare.
// The sign bit has inverted weight (a 1 means negative), every other bit
// has ordinary weight; the first differing bit decides the result.
module serial_cmp_cell
   import cmp_pkg::*;
(
   input  logic       a_bit,
   input  logic       b_bit,
   input  logic       is_msb,
   input  logic       decided,
   input  logic [1:0] verdict,
   output logic       next_decided,
   output logic [1:0] next_verdict
);

   // Evaluate the decision for this beat; a decided word is frozen.
   always_comb begin
      next_decided = decided;
      next_verdict = verdict;
      if (is_msb) begin
         next_decided = a_bit ^ b_bit;
         next_verdict = EQ;
         if (a_bit & ~b_bit) begin
            next_verdict = LT;
         end else if (~a_bit & b_bit) begin
            next_verdict = GT;
         end
      end else if (!decided && (a_bit ^ b_bit)) begin
         next_decided = 1'b1;
         next_verdict = a_bit ? GT : LT;
      end
   end

endmodule

// File: rtl/serial_signed_comparator.sv
// Bit-serial two's-complement comparator. Operands arrive MSB first, one
// bit-pair per accepted beat; the verdict is held until the consumer takes it.
//
// Handshake: a beat is accepted on a rising edge where in_valid & in_ready;
// in_ready depends on state only. The verdict is transferred on a rising
// edge where out_valid & out_ready; flags are stable while out_valid is high.
module serial_signed_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)(
   input  logic   clk,
   input  logic   reset,
   input  logic   in_valid,
   input  logic   in_first,
   input  logic   a_bit,
   input  logic   b_bit,
   output logic   in_ready,
   output logic   out_valid,
   input  logic   out_ready,
   output logic   altb,
   output logic   aeqb,
   output logic   agtb,
   output logic   err,
   output state_t dbg_state
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);
   // A one-bit word is complete as soon as its sign bit is accepted.
   localparam state_t        AFTER_MSB = (LAST == ONE) ? HOLD : SHIFT;

   state_t        r_state;
   logic [CW-1:0] r_count;
   logic          r_decided;
   logic [1:0]    r_verdict;
   logic          r_err;

   state_t        w_state_nxt;
   logic [CW-1:0] w_count_nxt;
   logic [CW-1:0] w_count_inc;
   logic          w_decided_nxt;
   logic [1:0]    w_verdict_nxt;
   logic          w_err_nxt;
   logic          w_accept;
   logic          w_cell_decided;
   logic [1:0]    w_cell_verdict;
   logic          w_in_ready;

   assign w_in_ready  = (r_state != HOLD);
   assign w_accept    = in_valid & w_in_ready;
   assign w_count_inc = r_count + ONE;

   serial_cmp_cell u_cell (
      .a_bit        (a_bit),
      .b_bit        (b_bit),
      .is_msb       (in_first),
      .decided      (r_decided),
      .verdict      (r_verdict),
      .next_decided (w_cell_decided),
      .next_verdict (w_cell_verdict)
   );

   // State, bit count, decision and error pulse registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_decided <= 1'b0;
         r_verdict <= EQ;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_decided <= w_decided_nxt;
         r_verdict <= w_verdict_nxt;
         r_err     <= w_err_nxt;
      end
   end

   // Next-state, counter and framing-error decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_decided_nxt = r_decided;
      w_verdict_nxt = r_verdict;
      w_err_nxt     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (in_first) begin
                  w_decided_nxt = w_cell_decided;
                  w_verdict_nxt = w_cell_verdict;
                  w_count_nxt   = ONE;
                  w_state_nxt   = AFTER_MSB;
               end else begin
                  // Stray non-first beat: dropped.
                  w_err_nxt = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (w_accept) begin
               w_decided_nxt = w_cell_decided;
               w_verdict_nxt = w_cell_verdict;
               if (in_first) begin
                  // Abort the partial word and restart on this sign bit.
                  w_err_nxt   = 1'b1;
                  w_count_nxt = ONE;
                  w_state_nxt = AFTER_MSB;
               end else begin
                  w_count_nxt = w_count_inc;
                  if (w_count_inc == LAST) begin
                     w_state_nxt = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign in_ready  = w_in_ready;
   assign out_valid = (r_state == HOLD);
   assign altb      = out_valid && (r_verdict == LT);
   assign aeqb      = out_valid && (r_verdict == EQ);
   assign agtb      = out_valid && (r_verdict == GT);
   assign err       = r_err;
   assign dbg_state = r_state;

endmodule
